// File: rtl/instr_encoder_loader.sv
// RV32I field-to-word encoder that streams packed instructions into instruction
// memory from a base address, with sticky encoding-error flags.
module instr_encoder_loader #(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [2:0]        err_flags
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic              last_seen, word_last;
  logic              accept, xfer;
  logic [31:0]       enc_word;
  logic [2:0]        enc_err;
  logic              fits12, fits13, fits21;

  assign in_ready = (state == RUN) && !last_seen && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = mem_we && mem_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Signed range checks: every bit above the field's sign bit must match it.
  assign fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign fits21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  always_comb begin
    enc_word = 32'h0000_0013;
    enc_err  = '0;
    case (in_op)
      OP_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: begin
        if (in_op == OP_IMM && (in_funct3 == 3'b001 || in_funct3 == 3'b101)) begin
          enc_word   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
          enc_err[1] = (in_imm[31:5] != '0);
        end else begin
          enc_word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
          enc_err[1] = !fits12;
        end
      end
      OP_STORE: begin
        enc_word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        enc_err[1] = !fits12;
      end
      OP_BR: begin
        enc_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_op};
        enc_err[1] = !fits13;
        enc_err[2] = in_imm[0];
      end
      OP_LUI, OP_AUIPC: enc_word = {in_imm[31:12], in_rd, in_op};
      OP_JAL: begin
        enc_word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        enc_err[1] = !fits21;
        enc_err[2] = in_imm[0];
      end
      default: enc_err[0] = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (xfer && word_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_seen <= 1'b0;
      word_last <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err_flags <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        mem_addr  <= base_addr & ~ADDR_W'(3);
        count     <= '0;
        err_flags <= '0;
      end
      if (state == DONE) last_seen <= 1'b0;
      // A new accept refills the single output slot in the same cycle it drains.
      if (accept) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc_word;
        word_last <= in_last;
        err_flags <= err_flags | enc_err;
        if (in_last) last_seen <= 1'b1;
      end else if (xfer) begin
        mem_we <= 1'b0;
      end
      if (xfer) begin
        mem_addr <= (mem_addr + ADDR_W'(4)) & ADDR_MASK;
        if (count != '1) count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: fixed instruction vectors, handshake corner
// sequences and randomized streams checked against an arithmetic encoder model.
module tb_instr_encoder_loader;
  localparam int ADDR_W = 12, MEM_BYTES = 4096, CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready, in_last;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [6:0]        in_op, in_funct7;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3, err_flags;
  logic [31:0]       in_imm, mem_wdata;
  logic              mem_we, mem_ready, busy, done;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .count(count), .err_flags(err_flags)
  );

  typedef struct {
    logic [6:0] op; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] imm; logic last;
  } bundle_t;
  typedef struct { bundle_t b; logic [31:0] word; logic [2:0] flags; } vec_t;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  int          exp_base = 0, k = 0;
  logic [2:0]  exp_flags = '0;
  bit          rnd_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: places each field by arithmetic weight, range checks on signed ints.
  function automatic void model(input bundle_t b, output logic [31:0] w, output logic [2:0] f);
    longint      s = longint'($signed(b.imm));
    logic [31:0] u = b.imm;
    logic [31:0] rd = 32'(b.rd) * 128, f3 = 32'(b.f3) * 4096;
    logic [31:0] rs1 = 32'(b.rs1) * 32768, rs2 = 32'(b.rs2) * 1048576;
    logic [31:0] f7 = 32'(b.f7) * 33554432, op = 32'(b.op);
    f = '0;
    case (b.op)
      7'h33: w = op + rd + f3 + rs1 + rs2 + f7;
      7'h13, 7'h03, 7'h67, 7'h73:
        if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
          w = op + rd + f3 + rs1 + (u % 32) * 1048576 + f7;
          f[1] = (s < 0 || s > 31);
        end else begin
          w = op + rd + f3 + rs1 + (u % 4096) * 1048576;
          f[1] = (s < -2048 || s > 2047);
        end
      7'h23: begin
        w = op + (u % 32) * 128 + f3 + rs1 + rs2 + ((u / 32) % 128) * 33554432;
        f[1] = (s < -2048 || s > 2047);
      end
      7'h63: begin
        w = op + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256 + f3 + rs1 + rs2
            + ((u / 32) % 64) * 33554432 + ((u / 4096) % 2) * 32'h8000_0000;
        f[1] = (s < -4096 || s > 4095);
        f[2] = (u % 2 == 1);
      end
      7'h37, 7'h17: w = op + rd + (u / 4096) * 4096;
      7'h6F: begin
        w = op + rd + ((u / 4096) % 256) * 4096 + ((u / 2048) % 2) * 1048576
            + ((u / 2) % 1024) * 2097152 + ((u / 1048576) % 2) * 32'h8000_0000;
        f[1] = (s < -1048576 || s > 1048575);
        f[2] = (u % 2 == 1);
      end
      default: begin w = 32'h13; f = 3'b001; end
    endcase
  endfunction

  function automatic vec_t mkv(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                               input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                               input logic last, input logic [31:0] word, input logic [2:0] flags);
    vec_t v;
    v.b.op = op; v.b.rd = rd; v.b.rs1 = rs1; v.b.rs2 = rs2; v.b.f3 = f3; v.b.f7 = f7;
    v.b.imm = imm; v.b.last = last; v.word = word; v.flags = flags;
    return v;
  endfunction

  // Write monitor: every transfer must match the next expected word and address,
  // and a stalled write must hold its address and data.
  initial begin
    bit stalled = 0;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0] st_data;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stalled) begin
          check("hold_we", 32'(mem_we), 32'd1);
          check("hold_addr", 32'(mem_addr), 32'(st_addr));
          check("hold_data", mem_wdata, st_data);
        end
        if (mem_we && mem_ready) begin
          if (exp_q.size() == 0) check("unexpected_write", mem_wdata, 32'hxxxx_xxxx);
          else begin
            check("wdata", mem_wdata, exp_q.pop_front());
            check("addr", 32'(mem_addr), 32'((exp_base + 4 * k) % MEM_BYTES));
          end
          k++;
        end
        stalled = mem_we && !mem_ready;
        st_addr = mem_addr;
        st_data = mem_wdata;
      end else stalled = 0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) mem_ready = 1'($urandom_range(0, 1));
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic do_start(input int b);
    base_addr = ADDR_W'(b); start = 1'b1;
    exp_base = b & ~3; k = 0; exp_flags = '0; exp_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input bundle_t b, input logic [31:0] w, input logic [2:0] f);
    bit acc = 0;
    int t = 0;
    in_op = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct3 = b.f3;
    in_funct7 = b.f7; in_imm = b.imm; in_last = b.last; in_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; t++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    else begin
      exp_q.push_back(w);
      exp_flags |= f;
      check("err_flags_after_accept", 32'(err_flags), 32'(exp_flags));
    end
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    bit seen = 0;
    while (!seen && t < 500) begin
      @(negedge clk); seen = done; t++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("count", 32'(count), 32'(n));
    check("err_flags_end", 32'(err_flags), 32'(exp_flags));
    check("pending_words", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  function automatic bundle_t rand_bundle(input logic last);
    logic [6:0] legal[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [6:0] bad[4] = '{7'h00, 7'h0B, 7'h7F, 7'h2F};
    bundle_t b;
    b.op = ($urandom_range(0, 11) == 0) ? bad[$urandom_range(0, 3)] : legal[$urandom_range(0, 9)];
    b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3 = 3'($urandom); b.f7 = 7'($urandom); b.last = last;
    case ($urandom_range(0, 3))
      0: b.imm = 32'($signed($urandom_range(0, 4095)) - 2048);
      1: b.imm = $urandom;
      2: b.imm = 32'($urandom_range(0, 31));
      default: b.imm = 32'($signed($urandom_range(0, 2097151)) - 1048576);
    endcase
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int bases[4] = '{0, 0, 'hFFC, 0};
    int run = 0, nw = 0;
    bundle_t b;
    logic [31:0] w;
    logic [2:0] f;

    vecs[0]  = mkv(7'h33, 3, 1, 2, 3'd0, 7'h00, 32'd0,        1'b0, 32'h002081B3, 3'b000);
    vecs[1]  = mkv(7'h13, 1, 1, 0, 3'd5, 7'h20, 32'd3,        1'b1, 32'h4030D093, 3'b000);
    vecs[2]  = mkv(7'h13, 1, 0, 0, 3'd0, 7'h00, 32'd5,        1'b0, 32'h00500093, 3'b000);
    vecs[3]  = mkv(7'h23, 0, 1, 2, 3'd2, 7'h00, 32'd8,        1'b0, 32'h0020A423, 3'b000);
    vecs[4]  = mkv(7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'd8,        1'b0, 32'h008000EF, 3'b000);
    vecs[5]  = mkv(7'h37, 5, 0, 0, 3'd0, 7'h00, 32'h12345000, 1'b1, 32'h123452B7, 3'b000);
    vecs[6]  = mkv(7'h13, 1, 0, 0, 3'd0, 7'h00, 32'd5,        1'b0, 32'h00500093, 3'b000);
    vecs[7]  = mkv(7'h13, 2, 0, 0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b1, 32'hFFF00113, 3'b000);
    vecs[8]  = mkv(7'h7F, 1, 2, 3, 3'd1, 7'h11, 32'd7,        1'b0, 32'h00000013, 3'b001);
    vecs[9]  = mkv(7'h13, 1, 0, 0, 3'd0, 7'h00, 32'd3000,     1'b0, 32'hBB800093, 3'b010);
    vecs[10] = mkv(7'h63, 0, 0, 0, 3'd0, 7'h00, 32'd5,        1'b1, 32'h00000263, 3'b100);
    vecs[11] = mkv(7'h33, 0, 0, 0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h00000033, 3'b000);

    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0;
    in_imm = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_err_flags", 32'(err_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table runs: R/shift, the four-word program, address wrap, error flags.
    for (int i = 0; i < 11; i++) begin
      if (nw == 0) begin
        do_start(bases[run]);
        check("busy_in_run", 32'(busy), 32'd1);
      end
      send(vecs[i].b, vecs[i].word, vecs[i].flags);
      nw++;
      if (vecs[i].b.last) begin
        wait_done(nw);
        nw = 0; run++;
      end
    end

    // Backpressure: the first word is held for three cycles with the input blocked.
    mem_ready = 1'b0;
    do_start('h100);
    fork
      begin
        send(vecs[2].b, vecs[2].word, vecs[2].flags);
        vecs[3].b.last = 1'b1;
        send(vecs[3].b, vecs[3].word, vecs[3].flags);
      end
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!mem_we && t < 50);
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          check("stall_we", 32'(mem_we), 32'd1);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_count", 32'(count), 32'd0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
      end
    join
    wait_done(2);

    // Reset with a write pending drops it and clears all state.
    do_start('h40);
    send(vecs[11].b, vecs[11].word, vecs[11].flags);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    send(vecs[8].b, vecs[8].word, vecs[8].flags);
    check("pre_rst_count", 32'(count), 32'd1);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_err_flags", 32'(err_flags), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; exp_q.delete(); mem_ready = 1'b1;
    @(posedge clk); #1;

    // Randomized streams with random base, gaps and memory backpressure.
    rnd_ready = 1;
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(8, 30);
      do_start(int'($urandom_range(0, MEM_BYTES - 1)));
      for (int j = 0; j < n; j++) begin
        b = rand_bundle(j == n - 1);
        model(b, w, f);
        send(b, w, f);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_done(n);
    end
    rnd_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
